// File: rtl/terminal_write_arbiter_if.sv
// Requester handshakes, clear control and terminal write port of the terminal write arbiter.
// The arbiter uses the slave modport; requesters and the terminal side use master.
interface terminal_write_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  logic                  clear_req;
  logic                  clear_busy;

  logic                  req0_valid;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;

  logic                  req1_valid;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;

  logic [ADDR_WIDTH-1:0] text_addr;
  logic                  text_write;
  logic [DATA_WIDTH-1:0] text_in;
  logic [7:0]            oob_count;

  modport slave (
    input  clear_req,
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output clear_busy,
    output req0_ready, req1_ready,
    output text_addr, text_write, text_in,
    output oob_count
  );

  modport master (
    output clear_req,
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  clear_busy,
    input  req0_ready, req1_ready,
    input  text_addr, text_write, text_in,
    input  oob_count
  );
endinterface

// File: rtl/terminal_write_arbiter.sv
// Round-robin arbiter for the terminal text-buffer write port with a hardware clear-screen pass.
// Out-of-range writes are accepted and dropped so requesters never stall.
module terminal_write_arbiter #(
  parameter int                  ADDR_WIDTH = 12,
  parameter int                  DATA_WIDTH = 8,
  parameter int                  CELLS      = 2400,
  parameter logic [DATA_WIDTH-1:0] CLEAR_CHAR = 8'h20
) (
  input logic clock,
  input logic reset,
  terminal_write_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH:0]   CELLS_EXT = (ADDR_WIDTH + 1)'(CELLS);
  localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(CELLS - 1);

  state_t                state;
  state_t                state_next;
  logic                  favour1;
  logic [ADDR_WIDTH-1:0] clear_cnt;

  logic                  grant0;
  logic                  grant1;
  logic                  xfer;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] xfer_addr;
  logic [DATA_WIDTH-1:0] xfer_data;

  logic [ADDR_WIDTH-1:0] text_addr_q;
  logic                  text_write_q;
  logic [DATA_WIDTH-1:0] text_in_q;
  logic [7:0]            oob_q;

  // A clear request in IDLE wins over both requesters for that cycle.
  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clear_req) begin
          state_next = CLEAR;
        end else if (bus.req0_valid && (!bus.req1_valid || !favour1)) begin
          grant0 = 1'b1;
        end else if (bus.req1_valid) begin
          grant1 = 1'b1;
        end
      end
      CLEAR: begin
        if (clear_cnt == LAST_CELL) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign xfer      = grant0 | grant1;
  assign xfer_addr = grant1 ? bus.req1_addr : bus.req0_addr;
  assign xfer_data = grant1 ? bus.req1_data : bus.req0_data;
  assign in_range  = {1'b0, xfer_addr} < CELLS_EXT;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      favour1   <= 1'b0;
      clear_cnt <= '0;
    end else begin
      state <= state_next;
      if (xfer) begin
        favour1 <= grant0;
      end
      if (state == CLEAR) begin
        clear_cnt <= (clear_cnt == LAST_CELL) ? '0 : clear_cnt + 1'b1;
      end
    end
  end

  // Terminal port is fully registered; address and data hold when no write occurs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      text_write_q <= 1'b0;
      text_addr_q  <= '0;
      text_in_q    <= '0;
    end else if (state == CLEAR) begin
      text_write_q <= 1'b1;
      text_addr_q  <= clear_cnt;
      text_in_q    <= CLEAR_CHAR;
    end else if (xfer && in_range) begin
      text_write_q <= 1'b1;
      text_addr_q  <= xfer_addr;
      text_in_q    <= xfer_data;
    end else begin
      text_write_q <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      oob_q <= '0;
    end else if (xfer && !in_range && oob_q != 8'hFF) begin
      oob_q <= oob_q + 8'd1;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.clear_busy = (state == CLEAR);
  assign bus.text_write = text_write_q;
  assign bus.text_addr  = text_addr_q;
  assign bus.text_in    = text_in_q;
  assign bus.oob_count  = oob_q;

endmodule
